// File: rtl/bsg_round_robin_n_to_1_buffered.sv
// bsg_round_robin_n_to_1_buffered
//
// Merges num_in_p worker lanes back into one stream in strict lane order
// (0,1,..,num_in_p-1,0,..), mirroring the order the upstream 1-to-N
// round-robin distributor handed work out. The merged stream passes through
// a 2-entry FIFO made of explicit head/tail registers, so data_o/lane_o are
// driven straight from flops. ready_o depends only on registered state,
// which means there is no combinational path from ready_i to ready_o.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   reset_n_i  : asynchronous active-low reset
//   valid_i    : per-lane valid
//   data_i     : lane i payload at [i*width_p +: width_p]
//   ready_o    : per-lane ready; only the currently selected lane can be set
//   valid_o    : FIFO not empty
//   data_o     : payload at FIFO head
//   lane_o     : source lane of the FIFO head
//   ready_i    : downstream accepts the head when valid_o & ready_i
module bsg_round_robin_n_to_1_buffered #(
  parameter int width_p  = 128,
  parameter int num_in_p = 32,
  localparam int lg_p    = $clog2(num_in_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_in_p-1:0]           valid_i,
  input  logic [num_in_p*width_p-1:0]   data_i,
  output logic [num_in_p-1:0]           ready_o,
  output logic                          valid_o,
  output logic [width_p-1:0]            data_o,
  output logic [lg_p-1:0]               lane_o,
  input  logic                          ready_i
);

  localparam logic [lg_p-1:0] last_lane_lp = lg_p'(num_in_p - 1);

  logic [lg_p-1:0]    ptr_r, ptr_next;
  logic [1:0]         count_r, count_next;
  logic [width_p-1:0] head_data_r, head_data_next;
  logic [lg_p-1:0]    head_lane_r, head_lane_next;
  logic [width_p-1:0] tail_data_r, tail_data_next;
  logic [lg_p-1:0]    tail_lane_r, tail_lane_next;

  logic [width_p-1:0] lane_data [num_in_p];
  logic               has_space;
  logic               enq;
  logic               deq;

  // Space is judged from the registered count only; a dequeue in the same
  // cycle does not reopen the input until the next cycle.
  assign has_space = (count_r != 2'd2);

  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_lane
      assign lane_data[gi] = data_i[gi*width_p +: width_p];
      assign ready_o[gi]   = has_space & (ptr_r == lg_p'(gi));
    end
  endgenerate

  // Only the selected lane is ever looked at: if it is idle the block waits,
  // even when other lanes are valid, so lane order is never broken.
  assign enq     = valid_i[ptr_r] & has_space;
  assign valid_o = (count_r != 2'd0);
  assign deq     = valid_o & ready_i;
  assign data_o  = head_data_r;
  assign lane_o  = head_lane_r;

  always_comb begin
    ptr_next       = ptr_r;
    count_next     = count_r;
    head_data_next = head_data_r;
    head_lane_next = head_lane_r;
    tail_data_next = tail_data_r;
    tail_lane_next = tail_lane_r;

    if (enq) begin
      ptr_next = (ptr_r == last_lane_lp) ? '0 : ptr_r + 1'b1;
    end

    case (count_r)
      2'd0: begin
        if (enq) begin
          head_data_next = lane_data[ptr_r];
          head_lane_next = ptr_r;
          count_next     = 2'd1;
        end
      end
      2'd1: begin
        if (enq && deq) begin
          // Head leaves and the new word replaces it directly.
          head_data_next = lane_data[ptr_r];
          head_lane_next = ptr_r;
        end else if (enq) begin
          tail_data_next = lane_data[ptr_r];
          tail_lane_next = ptr_r;
          count_next     = 2'd2;
        end else if (deq) begin
          count_next = 2'd0;
        end
      end
      2'd2: begin
        if (deq) begin
          head_data_next = tail_data_r;
          head_lane_next = tail_lane_r;
          count_next     = 2'd1;
        end
      end
      default: begin
        count_next = count_r;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r       <= '0;
      count_r     <= 2'd0;
      head_data_r <= '0;
      head_lane_r <= '0;
      tail_data_r <= '0;
      tail_lane_r <= '0;
    end else begin
      ptr_r       <= ptr_next;
      count_r     <= count_next;
      head_data_r <= head_data_next;
      head_lane_r <= head_lane_next;
      tail_data_r <= tail_data_next;
      tail_lane_r <= tail_lane_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(ready_o));
      assert (!(enq && (count_r == 2'd2)));
      assert (!(deq && (count_r == 2'd0)));
    end
  end

endmodule
